// File: rtl/rx_desc_ctrl_pkg.sv
// Shared constants for the receive descriptor ring controller.
// Holds the iDMA command field layout, engine status bit positions,
// the descriptor size and the iDMA FSM state encodings.
package rx_desc_ctrl_pkg;

    localparam int DESC_BYTES   = 16;

    // iDMA C1 beat: [31] dir, [27:16] byte count, [15:0] local address
    localparam int C1_DIR_BIT   = 31;
    localparam int C1_BYTES_LSB = 16;
    localparam logic DIR_IN     = 1'b0;   // host -> local
    localparam logic DIR_OUT    = 1'b1;   // local -> host

    // Engine status beat
    localparam int STAT_IDE     = 17;
    localparam int STAT_RS      = 16;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_FETCH_C1   = 4'd1;
    localparam logic [3:0] S_FETCH_C2   = 4'd2;
    localparam logic [3:0] S_FETCH_C3   = 4'd3;
    localparam logic [3:0] S_FETCH_WAIT = 4'd4;
    localparam logic [3:0] S_WB_C1      = 4'd5;
    localparam logic [3:0] S_WB_C2      = 4'd6;
    localparam logic [3:0] S_WB_C3      = 4'd7;
    localparam logic [3:0] S_WB_WAIT    = 4'd8;

    function automatic logic [31:0] idma_c1(input logic dir, input logic [11:0] bytes,
                                            input logic [15:0] laddr);
        return {dir, 3'b000, bytes, laddr};
    endfunction

    function automatic logic [16:0] min17(input logic [16:0] a, input logic [16:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic is_wb_state(input logic [3:0] s);
        return (s == S_WB_C1) || (s == S_WB_C2) || (s == S_WB_C3) || (s == S_WB_WAIT);
    endfunction

endpackage

// File: rtl/rx_ring_ptr.sv
// Modular ring index arithmetic.
//   idx_i   : current index
//   lim_i   : index to measure distance to (e.g. tail)
//   len_i   : ring length in entries
//   inc_i   : step to advance idx_i by (must not exceed len_i - idx_i... or wrap once)
//   avail_o : (lim_i - idx_i) mod len_i
//   next_o  : (idx_i + inc_i) mod len_i, single wrap
module rx_ring_ptr (
    input  logic [15:0] idx_i,
    input  logic [15:0] lim_i,
    input  logic [15:0] len_i,
    input  logic [15:0] inc_i,
    output logic [15:0] avail_o,
    output logic [15:0] next_o
);
    logic [16:0] diff;
    logic [16:0] sum;
    logic [16:0] wrapped;

    always_comb begin
        // 17-bit difference; sign bit set means lim is behind idx, so add len
        diff = {1'b0, lim_i} - {1'b0, idx_i};
        if (diff[16]) diff = diff + {1'b0, len_i};
        avail_o = diff[15:0];

        sum     = {1'b0, idx_i} + {1'b0, inc_i};
        wrapped = sum - {1'b0, len_i};
        next_o  = (sum >= {1'b0, len_i}) ? wrapped[15:0] : sum[15:0];
    end

endmodule

// File: rtl/rx_desc_ctrl.sv
// Receive descriptor ring controller.
// Fetches descriptors from the host ring into a local cache over iDMA,
// dispatches cached descriptor addresses to the receive engine, takes the
// engine's status, writes back RS descriptors, and advances RDH.
// Ports:
//   aclk/aresetn          clock, async active-low reset
//   enable, rdba, rdlen,  ring configuration and host tail
//   rdt
//   rdh                   host head (next descriptor to retire)
//   cmd_m_*               engine command stream (local descriptor address)
//   stat_s_*              engine status stream (IDE, RS, local address)
//   idma_m_*              3-beat iDMA command
//   idma_s_*              iDMA completion
//   desc_done(_ide)       per-retire pulse and its IDE qualifier
//   seq_err               sticky status-order error
module rx_desc_ctrl
    import rx_desc_ctrl_pkg::*;
#(
    parameter logic [15:0] DESC_BASE  = 16'h8000,
    parameter int          CACHE_DESC = 16,
    parameter int          MAX_FETCH  = 8
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        enable,
    input  logic [63:0] rdba,
    input  logic [15:0] rdlen,
    input  logic [15:0] rdt,
    output logic [15:0] rdh,
    output logic [31:0] cmd_m_tdata,
    output logic        cmd_m_tvalid,
    output logic        cmd_m_tlast,
    input  logic        cmd_m_tready,
    input  logic [31:0] stat_s_tdata,
    input  logic        stat_s_tvalid,
    input  logic        stat_s_tlast,
    output logic        stat_s_tready,
    output logic [31:0] idma_m_tdata,
    output logic        idma_m_tvalid,
    output logic        idma_m_tlast,
    input  logic        idma_m_tready,
    input  logic [31:0] idma_s_tdata,
    input  logic        idma_s_tvalid,
    input  logic        idma_s_tlast,
    output logic        idma_s_tready,
    output logic        desc_done,
    output logic        desc_done_ide,
    output logic        seq_err
);
    localparam int SW = $clog2(CACHE_DESC);

    logic [3:0]    state_q, state_d;
    logic [15:0]   fetch_idx_q, rdh_q, fetch_n_q;
    logic [SW-1:0] wr_slot_q, disp_slot_q, ret_slot_q;
    logic [SW:0]   cached_q, pending_q;
    logic          wb_pend_q, wb_pend_d, wb_ide_q;
    logic [15:0]   wb_addr_q;
    logic          cmd_hold_q, stat_rdy_q, stat_rdy_d;
    logic          desc_done_q, desc_done_ide_q, seq_err_q;

    logic [15:0]   avail, fetch_next, rdh_next, rdh_lag_unused, fetch_n;
    logic [16:0]   n_full;
    logic          stat_acc, stat_rs, fetch_done, wb_done, retire, ret_ide, cmd_hs, drop;
    logic [63:0]   fetch_host, wb_host;
    logic          unused_ok;

    function automatic logic [15:0] slot_addr(input logic [SW-1:0] s);
        return DESC_BASE + 16'(s) * 16'(DESC_BYTES);
    endfunction

    rx_ring_ptr u_fetch_ptr (
        .idx_i(fetch_idx_q), .lim_i(rdt), .len_i(rdlen), .inc_i(fetch_n_q),
        .avail_o(avail), .next_o(fetch_next)
    );

    rx_ring_ptr u_rdh_ptr (
        .idx_i(rdh_q), .lim_i(fetch_idx_q), .len_i(rdlen), .inc_i(16'd1),
        .avail_o(rdh_lag_unused), .next_o(rdh_next)
    );

    // Burst size: host availability, cache room, burst cap, and neither
    // the ring end nor the cache end may be crossed by one burst.
    always_comb begin
        n_full = min17(min17({1'b0, avail}, 17'(CACHE_DESC) - 17'(cached_q)),
                       min17(17'(MAX_FETCH),
                             min17({1'b0, rdlen} - {1'b0, fetch_idx_q},
                                   17'(CACHE_DESC) - 17'(wr_slot_q))));
        fetch_n = n_full[15:0];
    end

    assign stat_s_tready = stat_rdy_q;
    assign idma_s_tready = 1'b1;
    assign stat_acc      = stat_s_tvalid && stat_rdy_q;
    assign stat_rs       = stat_s_tdata[STAT_RS];
    assign fetch_done    = (state_q == S_FETCH_WAIT) && idma_s_tvalid;
    assign wb_done       = (state_q == S_WB_WAIT) && idma_s_tvalid;
    assign retire        = (stat_acc && !stat_rs) || wb_done;
    assign ret_ide       = wb_done ? wb_ide_q : stat_s_tdata[STAT_IDE];

    // Once raised, valid is held by cmd_hold_q even if enable drops.
    assign cmd_m_tvalid  = cmd_hold_q || ((pending_q != '0) && enable);
    assign cmd_m_tdata   = {16'b0, slot_addr(disp_slot_q)};
    assign cmd_m_tlast   = 1'b1;
    assign cmd_hs        = cmd_m_tvalid && cmd_m_tready;

    // Disabled and quiescent: everything dispatched has been retired.
    assign drop = !enable && (state_q == S_IDLE) && (cached_q == pending_q) &&
                  !wb_pend_q && !cmd_hold_q;

    assign fetch_host = rdba + 64'(fetch_idx_q) * 64'(DESC_BYTES);
    assign wb_host    = rdba + 64'(rdh_q) * 64'(DESC_BYTES);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (wb_pend_q)                        state_d = S_WB_C1;
                else if (enable && (fetch_n != '0))   state_d = S_FETCH_C1;
            end
            S_FETCH_C1:   if (idma_m_tready) state_d = S_FETCH_C2;
            S_FETCH_C2:   if (idma_m_tready) state_d = S_FETCH_C3;
            S_FETCH_C3:   if (idma_m_tready) state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: if (idma_s_tvalid) state_d = S_IDLE;
            S_WB_C1:      if (idma_m_tready) state_d = S_WB_C2;
            S_WB_C2:      if (idma_m_tready) state_d = S_WB_C3;
            S_WB_C3:      if (idma_m_tready) state_d = S_WB_WAIT;
            S_WB_WAIT:    if (idma_s_tvalid) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase

        wb_pend_d = wb_pend_q;
        if (wb_done)             wb_pend_d = 1'b0;
        if (stat_acc && stat_rs) wb_pend_d = 1'b1;
        stat_rdy_d = !wb_pend_d && !is_wb_state(state_d);
    end

    always_comb begin
        idma_m_tvalid = 1'b0;
        idma_m_tlast  = 1'b0;
        idma_m_tdata  = '0;
        case (state_q)
            S_FETCH_C1: idma_m_tdata = idma_c1(DIR_IN, 12'(fetch_n_q) * 12'(DESC_BYTES),
                                               slot_addr(wr_slot_q));
            S_FETCH_C2: idma_m_tdata = fetch_host[31:0];
            S_FETCH_C3: idma_m_tdata = fetch_host[63:32];
            S_WB_C1:    idma_m_tdata = idma_c1(DIR_OUT, 12'(DESC_BYTES), wb_addr_q);
            S_WB_C2:    idma_m_tdata = wb_host[31:0];
            S_WB_C3:    idma_m_tdata = wb_host[63:32];
            default:    idma_m_tdata = '0;
        endcase
        case (state_q)
            S_FETCH_C1, S_FETCH_C2, S_FETCH_C3,
            S_WB_C1, S_WB_C2, S_WB_C3: idma_m_tvalid = 1'b1;
            default:                   idma_m_tvalid = 1'b0;
        endcase
        idma_m_tlast = (state_q == S_FETCH_C3) || (state_q == S_WB_C3);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= S_IDLE;
            fetch_idx_q     <= '0;
            rdh_q           <= '0;
            fetch_n_q       <= '0;
            wr_slot_q       <= '0;
            disp_slot_q     <= '0;
            ret_slot_q      <= '0;
            cached_q        <= '0;
            pending_q       <= '0;
            wb_pend_q       <= 1'b0;
            wb_ide_q        <= 1'b0;
            wb_addr_q       <= '0;
            cmd_hold_q      <= 1'b0;
            stat_rdy_q      <= 1'b0;
            desc_done_q     <= 1'b0;
            desc_done_ide_q <= 1'b0;
            seq_err_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_pend_q  <= wb_pend_d;
            stat_rdy_q <= stat_rdy_d;
            cmd_hold_q <= cmd_m_tvalid && !cmd_m_tready;

            // C1 is frozen once the FSM leaves idle
            if ((state_q == S_IDLE) && (state_d == S_FETCH_C1)) fetch_n_q <= fetch_n;

            if (fetch_done) begin
                fetch_idx_q <= fetch_next;
                wr_slot_q   <= wr_slot_q + fetch_n_q[SW-1:0];
            end
            cached_q  <= cached_q + (fetch_done ? fetch_n_q[SW:0] : '0)
                                  - {{SW{1'b0}}, retire};
            pending_q <= pending_q + (fetch_done ? fetch_n_q[SW:0] : '0)
                                   - {{SW{1'b0}}, cmd_hs};
            if (cmd_hs) disp_slot_q <= disp_slot_q + SW'(1);

            if (stat_acc && (stat_s_tdata[15:0] != slot_addr(ret_slot_q))) seq_err_q <= 1'b1;
            if (stat_acc && stat_rs) begin
                wb_addr_q <= stat_s_tdata[15:0];
                wb_ide_q  <= stat_s_tdata[STAT_IDE];
            end

            if (retire) begin
                rdh_q      <= rdh_next;
                ret_slot_q <= ret_slot_q + SW'(1);
            end
            desc_done_q     <= retire;
            desc_done_ide_q <= retire && ret_ide;

            if (drop) begin
                fetch_idx_q <= '0;
                rdh_q       <= '0;
                wr_slot_q   <= '0;
                disp_slot_q <= '0;
                ret_slot_q  <= '0;
                cached_q    <= '0;
                pending_q   <= '0;
            end
        end
    end

    assign rdh           = rdh_q;
    assign desc_done     = desc_done_q;
    assign desc_done_ide = desc_done_ide_q;
    assign seq_err       = seq_err_q;

    assign unused_ok = ^{stat_s_tdata[31:18], stat_s_tlast, idma_s_tdata, idma_s_tlast};

endmodule

// File: doc/rx_desc_ctrl.md
Name: rx_desc_ctrl

Overview:
Receive descriptor ring controller that sits directly upstream of the receive engine. It fetches descriptors from the host ring into a local descriptor cache through the iDMA port and dispatches their local addresses to the engine's command port. It then consumes the engine's status, writes the descriptor back to the host, and advances the ring head. It owns RDH tracking and the per-descriptor completion pulses.

Parameters:
DESC_BASE, 16'h8000, local byte address of cache slot 0; slot n sits at DESC_BASE+16*n
CACHE_DESC, 16, number of cache slots (power of two)
MAX_FETCH, 8, maximum descriptors per iDMA fetch burst

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
enable  in  1  ring enable (RCTL.EN)
rdba  in  64  ring base address, 16-byte aligned
rdlen  in  16  ring size in descriptors, ≥2
rdt  in  16  host tail index
rdh  out  16  host head index (next descriptor to retire)
cmd_m_tdata/tvalid/tlast/tready  out/out/out/in  32/1/1/1  engine command: [15:0] local descriptor address
stat_s_tdata/tvalid/tlast/tready  in/in/in/out  32/1/1/1  engine status: [17] IDE, [16] RS, [15:0] local address
idma_m_tdata/tvalid/tlast/tready  out/out/out/in  32/1/1/1  iDMA command, 3 beats: C1 [31] dir (0 = host→local, 1 = local→host), [27:16] bytes, [15:0] local address; C2 address[31:0]; C3 address[63:32]
idma_s_tdata/tvalid/tlast/tready  in/in/in/out  32/1/1/1  iDMA completion, single beat
desc_done  out  1  one-cycle pulse per retired descriptor
desc_done_ide  out  1  qualifies desc_done with the IDE bit
seq_err  out  1  sticky; set on a status-address mismatch

Behaviour:
- Reset: all pointers and counters 0; rdh=0; all tvalid=0; stat_s_tready=0; idma_s_tready=1; desc_done/desc_done_ide/seq_err=0; FSM in S_IDLE.
- Internal state:
  - fetch_idx: host index of the next descriptor to fetch.
  - cache slot pointers wr_slot, disp_slot, ret_slot, each log2(CACHE_DESC) bits, wrapping naturally.
  - cached (0..CACHE_DESC): descriptors fetched but not yet retired.
  - pending (0..CACHE_DESC): descriptors fetched but not yet dispatched.
- Host availability: avail = (rdt-fetch_idx) mod rdlen, computed 17-bit and corrected by adding rdlen when negative. rdt==fetch_idx means empty.
- Fetch count: n = min(avail, CACHE_DESC-cached, MAX_FETCH, rdlen-fetch_idx, CACHE_DESC-wr_slot).
  - The rdlen-fetch_idx term stops a burst from crossing the ring end.
  - The CACHE_DESC-wr_slot term stops a burst from crossing the cache end.
  - Bytes field = n*16.
- iDMA FSM:
  - S_IDLE → S_WB_C1 if a writeback is pending (priority). Otherwise → S_FETCH_C1 if enable && n>0.
  - S_FETCH_C1/C2/C3: each advances on idma_m_tready; tlast only on C3. C1 = {1'b0, 3'b0, n*16, DESC_BASE+16*wr_slot}; address = rdba + 16*fetch_idx.
  - S_FETCH_WAIT: on idma_s_tvalid → fetch_idx += n (wrap to 0 at rdlen), wr_slot += n, cached += n, pending += n; → S_IDLE.
  - S_WB_C1/C2/C3: C1 = {1'b1, 3'b0, 12'd16, latched local address}; address = rdba + 16*rdh.
  - S_WB_WAIT: on idma_s_tvalid → retire; → S_IDLE.
- Dispatch (independent of the iDMA FSM):
  - While pending>0 && enable: cmd_m_tvalid=1, tdata={16'b0, DESC_BASE+16*disp_slot}, tlast=1.
  - On handshake: disp_slot++, pending--.
  - tvalid, once asserted, holds with stable data until accepted.
- Status intake:
  - stat_s_tready=1 only when no writeback is pending and the FSM is not in a WB state.
  - On accept: compare [15:0] against DESC_BASE+16*ret_slot; on mismatch set seq_err (processing continues).
  - RS=1: latch address and IDE, mark writeback pending.
  - RS=0: retire in the same cycle.
- Retire: rdh <= (rdh+1==rdlen) ? 0 : rdh+1; ret_slot++; cached--; pulse desc_done; desc_done_ide=IDE.
- Simultaneous fetch completion and retire: cached updates by +n-1 in one cycle.
- enable low:
  - No new fetch or dispatch starts; outstanding iDMA and writeback operations complete.
  - Once the FSM is idle and cached==pending, fetch_idx, rdh and all slots clear to 0 and the cache is dropped.
- rdt changes take effect on the next fetch calculation. Once the FSM has left S_IDLE, a C1 beat is not recalculated.
- Reset mid-operation: everything returns to reset values immediately; no handshake is completed.

Decomposition:
- Shared package:
  - iDMA C1 field offsets and direction constants (DIR_IN=0, DIR_OUT=1).
  - Status bit positions (STAT_IDE=17, STAT_RS=16).
  - DESC_BYTES=16.
  - iDMA FSM state encodings.
- One natural sub-module, rx_ring_ptr: modular index arithmetic (avail, wrap increment by n). It is instantiated for fetch_idx and rdh.

Test Plan:
1. rdlen=8, rdt=3, enable=1 → one fetch with bytes=48, local 8000, host rdba; then three cmd beats 8000, 8010, 8020.
2. Reply to status {RS=1, addr 8000} → iDMA OUT 16 bytes from 8000 to rdba+0; after completion, rdh=1 and desc_done pulses once.
3. rdlen=8, fetch_idx=6, rdt=2 → two bursts: n=2 to host indices 6-7, then n=2 from index 0; fetch_idx ends at 2.
4. CACHE_DESC=16, rdt far ahead, status withheld → fetches stop at cached=16. One RS=0 status retires a slot and frees one for the next fetch.
5. Status address 8010 when 8000 is expected → seq_err=1 (sticky) and rdh still increments.
6. Drop enable mid-fetch → the fetch completes, no cmd is issued, and fetch_idx, rdh and cached are 0 once the FSM is idle.
